// File: rtl/axi_noc_pkg.sv
// Shared AXI encodings, BIST FSM states and the address-derived data pattern
// used by the AXI RAM BIST master.
package axi_noc_pkg;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

   typedef enum logic [2:0] {
      S_IDLE,
      S_AW,
      S_W,
      S_B,
      S_AR,
      S_R,
      S_DONE
   } bist_state_t;

   // One 64-bit pattern lane: inverted address in the upper half.
   function automatic logic [63:0] pat(input logic [31:0] a);
      return {~a, a};
   endfunction

endpackage

// File: rtl/axi_ram_bist_master_if.sv
// AXI4 bus between the BIST master and an axi2ram slave port.
interface axi_ram_bist_master_if #(
   parameter int IDWID = 4,
   parameter int DWID  = 64
) ();
   localparam int WSTRB = DWID / 8;

   logic [31:0]       awaddr;
   logic [1:0]        awburst;
   logic [IDWID-1:0]  awid;
   logic [7:0]        awlen;
   logic [2:0]        awsize;
   logic              awvalid;
   logic              awready;
   logic [DWID-1:0]   wdata;
   logic [WSTRB-1:0]  wstrb;
   logic              wlast;
   logic              wvalid;
   logic              wready;
   logic [IDWID-1:0]  bid;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [31:0]       araddr;
   logic [1:0]        arburst;
   logic [IDWID-1:0]  arid;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic              arvalid;
   logic              arready;
   logic [DWID-1:0]   rdata;
   logic [IDWID-1:0]  rid;
   logic [1:0]        rresp;
   logic              rlast;
   logic              rvalid;
   logic              rready;

   modport master (
      output awaddr, awburst, awid, awlen, awsize, awvalid, input awready,
      output wdata, wstrb, wlast, wvalid, input wready,
      input  bid, bresp, bvalid, output bready,
      output araddr, arburst, arid, arlen, arsize, arvalid, input arready,
      input  rdata, rid, rresp, rlast, rvalid, output rready
   );

   modport slave (
      input  awaddr, awburst, awid, awlen, awsize, awvalid, output awready,
      input  wdata, wstrb, wlast, wvalid, output wready,
      output bid, bresp, bvalid, input bready,
      input  araddr, arburst, arid, arlen, arsize, arvalid, output arready,
      output rdata, rid, rresp, rlast, rvalid, input rready
   );
endinterface

// File: rtl/axi_bist_addr_gen.sv
// Burst/beat counters and running beat address for the BIST write and read
// phases; the region is contiguous, so the address simply steps by WSTRB.
module axi_bist_addr_gen #(
   parameter int WSTRB = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        init,
   input  logic        restart,
   input  logic        beat_adv,
   input  logic        burst_adv,
   input  logic [31:0] base_addr,
   input  logic [7:0]  nbursts,
   input  logic [7:0]  blen,
   output logic [31:0] start_addr,
   output logic [31:0] beat_addr,
   output logic [31:0] next_addr,
   output logic [7:0]  len,
   output logic [7:0]  next_burst_idx,
   output logic        last_beat,
   output logic        next_last,
   output logic        last_burst
);
   logic [7:0] nb_q;
   logic [7:0] beat_q;
   logic [7:0] burst_q;

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_addr <= '0;
         beat_addr  <= '0;
         len        <= '0;
         nb_q       <= '0;
         beat_q     <= '0;
         burst_q    <= '0;
      end else if (init) begin
         start_addr <= base_addr;
         beat_addr  <= base_addr;
         len        <= blen;
         nb_q       <= nbursts;
         beat_q     <= '0;
         burst_q    <= '0;
      end else if (restart) begin
         beat_addr <= start_addr;
         beat_q    <= '0;
         burst_q   <= '0;
      end else begin
         if (beat_adv) begin
            beat_addr <= next_addr;
            beat_q    <= last_beat ? 8'd0 : beat_q + 8'd1;
         end
         if (burst_adv) burst_q <= burst_q + 8'd1;
      end
   end

   // nbursts==0 wraps to 255 here, giving the 256-burst case for free.
   assign next_addr      = beat_addr + 32'(WSTRB);
   assign next_burst_idx = burst_q + 8'd1;
   assign last_beat      = (beat_q == len);
   assign next_last      = ((beat_q + 8'd1) == len);
   assign last_burst     = (burst_q == (nb_q - 8'd1));
endmodule

// File: rtl/axi_ram_bist_master.sv
// AXI4 BIST master: writes an address-derived pattern in INCR bursts, reads it
// back, and reports mismatches, response errors and handshake timeouts.
module axi_ram_bist_master
   import axi_noc_pkg::*;
#(
   parameter int IDWID   = 4,
   parameter int DWID    = 64,
   parameter int TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] base_addr,
   input  logic [7:0]  nbursts,
   input  logic [7:0]  blen,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        timeout,
   output logic [15:0] err_cnt,
   axi_ram_bist_master_if.master bus
);
   localparam int         WSTRB = DWID / 8;
   localparam logic [2:0] SIZE  = 3'($clog2(WSTRB));
   localparam int         WD_W  = $clog2(TIMEOUT + 1);

   bist_state_t      state;
   logic [WD_W-1:0]  wd_cnt;
   logic             awvalid_q, wvalid_q, wlast_q, bready_q, arvalid_q, rready_q;
   logic [31:0]      awaddr_q, araddr_q;
   logic [IDWID-1:0] awid_q, arid_q;
   logic [DWID-1:0]  wdata_q, exp_rdata;
   logic             hs, beat_err, wd_expire, idle;
   logic [15:0]      err_next;

   logic [31:0] start_addr, beat_addr, next_addr;
   logic [7:0]  len, next_burst_idx;
   logic        last_beat, next_last, last_burst;
   logic        gen_init, gen_restart, gen_beat_adv, gen_burst_adv;

   axi_bist_addr_gen #(.WSTRB(WSTRB)) u_addr_gen (
      .clk           (clk),
      .rst_n         (rst_n),
      .init          (gen_init),
      .restart       (gen_restart),
      .beat_adv      (gen_beat_adv),
      .burst_adv     (gen_burst_adv),
      .base_addr     (base_addr),
      .nbursts       (nbursts),
      .blen          (blen),
      .start_addr    (start_addr),
      .beat_addr     (beat_addr),
      .next_addr     (next_addr),
      .len           (len),
      .next_burst_idx(next_burst_idx),
      .last_beat     (last_beat),
      .next_last     (next_last),
      .last_burst    (last_burst)
   );

   assign idle          = (state == S_IDLE) || (state == S_DONE);
   assign gen_init      = idle && start;
   assign gen_restart   = (state == S_B) && bus.bvalid && last_burst;
   assign gen_beat_adv  = ((state == S_W) && bus.wready) || ((state == S_R) && bus.rvalid);
   assign gen_burst_adv = ((state == S_B) && bus.bvalid && !last_burst) ||
                          ((state == S_R) && bus.rvalid && last_beat && !last_burst);
   assign exp_rdata     = {(DWID/64){pat(beat_addr)}};

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      hs       = 1'b0;
      beat_err = 1'b0;
      case (state)
         S_AW: hs = awvalid_q && bus.awready;
         S_W:  hs = wvalid_q && bus.wready;
         S_B: begin
            hs       = bready_q && bus.bvalid;
            beat_err = hs && ((bus.bresp != RESP_OKAY) || (bus.bid != awid_q));
         end
         S_AR: hs = arvalid_q && bus.arready;
         S_R: begin
            hs       = rready_q && bus.rvalid;
            beat_err = hs && ((bus.rdata != exp_rdata) || (bus.rresp != RESP_OKAY) ||
                              (bus.rid != arid_q) || (bus.rlast != last_beat));
         end
         default: hs = 1'b0;
      endcase
   end

   assign err_next  = (beat_err && (err_cnt != 16'hFFFF)) ? err_cnt + 16'd1 : err_cnt;
   assign wd_expire = !idle && !hs && (wd_cnt == WD_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         wd_cnt    <= '0;
         awvalid_q <= 1'b0;
         awaddr_q  <= '0;
         awid_q    <= '0;
         wvalid_q  <= 1'b0;
         wdata_q   <= '0;
         wlast_q   <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         araddr_q  <= '0;
         arid_q    <= '0;
         rready_q  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         timeout   <= 1'b0;
         err_cnt   <= '0;
      end else begin
         err_cnt <= err_next;
         wd_cnt  <= (idle || hs) ? '0 : wd_cnt + 1'b1;
         if (wd_expire) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= 1'b0;
            timeout   <= 1'b1;
            state     <= S_DONE;
         end else begin
            case (state)
               S_IDLE, S_DONE: if (start) begin
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  timeout   <= 1'b0;
                  err_cnt   <= '0;
                  awvalid_q <= 1'b1;
                  awaddr_q  <= base_addr;
                  awid_q    <= '0;
                  state     <= S_AW;
               end
               S_AW: if (bus.awready) begin
                  awvalid_q <= 1'b0;
                  wvalid_q  <= 1'b1;
                  wdata_q   <= {(DWID/64){pat(beat_addr)}};
                  wlast_q   <= last_beat;
                  state     <= S_W;
               end
               S_W: if (bus.wready) begin
                  if (last_beat) begin
                     wvalid_q <= 1'b0;
                     wlast_q  <= 1'b0;
                     bready_q <= 1'b1;
                     state    <= S_B;
                  end else begin
                     wdata_q <= {(DWID/64){pat(next_addr)}};
                     wlast_q <= next_last;
                  end
               end
               S_B: if (bus.bvalid) begin
                  bready_q <= 1'b0;
                  if (last_burst) begin
                     arvalid_q <= 1'b1;
                     araddr_q  <= start_addr;
                     arid_q    <= '0;
                     state     <= S_AR;
                  end else begin
                     awvalid_q <= 1'b1;
                     awaddr_q  <= beat_addr;
                     awid_q    <= IDWID'(next_burst_idx);
                     state     <= S_AW;
                  end
               end
               S_AR: if (bus.arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state     <= S_R;
               end
               S_R: if (bus.rvalid && last_beat) begin
                  rready_q <= 1'b0;
                  if (last_burst) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (err_next == 16'd0);
                     state <= S_DONE;
                  end else begin
                     arvalid_q <= 1'b1;
                     araddr_q  <= next_addr;
                     arid_q    <= IDWID'(next_burst_idx);
                     state     <= S_AR;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.awaddr  = awaddr_q;
   assign bus.awburst = BURST_INCR;
   assign bus.awid    = awid_q;
   assign bus.awlen   = len;
   assign bus.awsize  = SIZE;
   assign bus.awvalid = awvalid_q;
   assign bus.wdata   = wdata_q;
   assign bus.wstrb   = '1;
   assign bus.wlast   = wlast_q;
   assign bus.wvalid  = wvalid_q;
   assign bus.bready  = bready_q;
   assign bus.araddr  = araddr_q;
   assign bus.arburst = BURST_INCR;
   assign bus.arid    = arid_q;
   assign bus.arlen   = len;
   assign bus.arsize  = SIZE;
   assign bus.arvalid = arvalid_q;
   assign bus.rready  = rready_q;
endmodule

// File: tb/tb_axi_ram_bist_master.sv
// Bench for axi_ram_bist_master: behavioural axi2ram slave with a write/address
// scoreboard, payload-stability monitor and one task per scenario.
module tb_axi_ram_bist_master;
   localparam int IDWID = 4;
   localparam int DWID  = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] base_addr = '0;
   logic [7:0]  nbursts = '0;
   logic [7:0]  blen = '0;
   logic        busy, done, pass, timeout;
   logic [15:0] err_cnt;

   int checks = 0;
   int failures = 0;

   axi_ram_bist_master_if #(.IDWID(IDWID), .DWID(DWID)) bus ();

   axi_ram_bist_master #(.IDWID(IDWID), .DWID(DWID), .TIMEOUT(1024)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .base_addr(base_addr),
      .nbursts  (nbursts),
      .blen     (blen),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .timeout  (timeout),
      .err_cnt  (err_cnt),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   // Slave memory and scoreboard queues
   logic [63:0]      mem [logic [31:0]];
   logic [31:0]      exp_w_addr[$];
   logic [63:0]      exp_w_data[$];
   logic [31:0]      exp_aw[$];
   logic [31:0]      exp_ar[$];
   bit               bp, aw_stall, corrupt_en;
   int               aw_cnt, ar_cnt, w_seen;
   logic [63:0]      first_wdata;
   logic [31:0]      w_base, w_a, r_a, e_a;
   logic [63:0]      e_d;
   logic [7:0]       w_len;
   logic [IDWID-1:0] w_id;
   int               w_beat, r_beat;
   logic [IDWID-1:0] b_idq[$];
   logic [31:0]      rq_addr[$];
   logic [7:0]       rq_len[$];
   logic [IDWID-1:0] rq_id[$];
   bit               b_fire, r_fire, hold_aw, hold_w, hold_ar, h_wlast;
   logic [31:0]      h_awaddr, h_araddr;
   logic [63:0]      h_wdata;

   // Slave drives and samples at negedge; a handshake happens on the following posedge.
   initial begin
      bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bid = '0; bus.bresp = '0;
      bus.arready = 0; bus.rvalid = 0; bus.rdata = '0; bus.rid = '0; bus.rresp = '0;
      bus.rlast = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.arready = 0; bus.rvalid = 0;
            b_idq.delete(); rq_addr.delete(); rq_len.delete(); rq_id.delete();
            b_fire = 0; r_fire = 0; hold_aw = 0; hold_w = 0; hold_ar = 0;
            w_beat = 0; r_beat = 0;
         end else begin
            if (hold_aw && !timeout) begin
               checks++;
               if (bus.awvalid !== 1'b1 || bus.awaddr !== h_awaddr) begin
                  failures++;
                  $display("FAIL aw_stable: awvalid=%b awaddr=%h, required 1 and %h", bus.awvalid, bus.awaddr, h_awaddr);
               end
            end
            if (hold_w && !timeout) begin
               checks++;
               if (bus.wvalid !== 1'b1 || bus.wdata !== h_wdata || bus.wlast !== h_wlast) begin
                  failures++;
                  $display("FAIL w_stable: wvalid=%b wdata=%h wlast=%b, required 1 %h %b", bus.wvalid, bus.wdata, bus.wlast, h_wdata, h_wlast);
               end
            end
            if (hold_ar && !timeout) begin
               checks++;
               if (bus.arvalid !== 1'b1 || bus.araddr !== h_araddr) begin
                  failures++;
                  $display("FAIL ar_stable: arvalid=%b araddr=%h, required 1 and %h", bus.arvalid, bus.araddr, h_araddr);
               end
            end
            // R channel
            if (bus.rvalid && r_fire) begin
               if (r_beat == int'(rq_len[0])) begin
                  void'(rq_addr.pop_front()); void'(rq_len.pop_front()); void'(rq_id.pop_front());
                  r_beat = 0;
               end else r_beat++;
               bus.rvalid = 0;
            end
            if (!bus.rvalid && rq_addr.size() > 0 && (!bp || $urandom_range(0, 2) != 0)) begin
               r_a = rq_addr[0] + 32'(r_beat * 8);
               bus.rdata  = mem.exists(r_a) ? mem[r_a] : 64'h0;
               bus.rid    = rq_id[0];
               bus.rlast  = (r_beat == int'(rq_len[0]));
               bus.rresp  = 2'b00;
               bus.rvalid = 1;
            end
            r_fire = bus.rvalid && bus.rready;
            // B channel
            if (bus.bvalid && b_fire) bus.bvalid = 0;
            if (!bus.bvalid && b_idq.size() > 0) begin
               bus.bid = b_idq.pop_front(); bus.bresp = 2'b00; bus.bvalid = 1;
            end
            b_fire = bus.bvalid && bus.bready;
            // AW channel
            bus.awready = aw_stall ? 1'b0 : (bp ? ($urandom_range(0, 1) == 1) : 1'b1);
            if (bus.awvalid && bus.awready) begin
               checks++;
               if (exp_aw.size() == 0) begin
                  failures++;
                  $display("FAIL aw_unexpected: awaddr=%h, required no AW", bus.awaddr);
               end else begin
                  e_a = exp_aw.pop_front();
                  if (bus.awaddr !== e_a || bus.awid !== IDWID'(aw_cnt) || bus.awlen !== blen ||
                      bus.awsize !== 3'd3 || bus.awburst !== 2'b01) begin
                     failures++;
                     $display("FAIL aw_beat: addr=%h id=%h len=%h size=%h burst=%b, required %h %h %h 3 01",
                              bus.awaddr, bus.awid, bus.awlen, bus.awsize, bus.awburst, e_a, IDWID'(aw_cnt), blen);
                  end
               end
               w_base = bus.awaddr; w_len = bus.awlen; w_id = bus.awid; w_beat = 0; aw_cnt++;
            end
            hold_aw = bus.awvalid && !bus.awready;
            h_awaddr = bus.awaddr;
            // W channel
            bus.wready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (bus.wvalid && bus.wready) begin
               w_a = w_base + 32'(w_beat * 8);
               mem[w_a] = bus.wdata;
               if (w_seen == 0) first_wdata = bus.wdata;
               w_seen++;
               checks++;
               if (exp_w_addr.size() == 0) begin
                  failures++;
                  $display("FAIL w_unexpected: addr=%h data=%h, required no W beat", w_a, bus.wdata);
               end else begin
                  e_a = exp_w_addr.pop_front();
                  e_d = exp_w_data.pop_front();
                  if (w_a !== e_a || bus.wdata !== e_d || bus.wlast !== (w_beat == int'(w_len)) || bus.wstrb !== 8'hFF) begin
                     failures++;
                     $display("FAIL w_beat: addr=%h data=%h wlast=%b wstrb=%h, required %h %h %b FF",
                              w_a, bus.wdata, bus.wlast, bus.wstrb, e_a, e_d, (w_beat == int'(w_len)));
                  end
               end
               if (bus.wlast) b_idq.push_back(w_id);
               w_beat++;
            end
            hold_w = bus.wvalid && !bus.wready;
            h_wdata = bus.wdata; h_wlast = bus.wlast;
            // AR channel
            bus.arready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (bus.arvalid && bus.arready) begin
               if (corrupt_en) begin
                  mem[32'h110] = mem[32'h110] ^ 64'h1;
                  corrupt_en = 0;
               end
               checks++;
               if (exp_ar.size() == 0) begin
                  failures++;
                  $display("FAIL ar_unexpected: araddr=%h, required no AR", bus.araddr);
               end else begin
                  e_a = exp_ar.pop_front();
                  if (bus.araddr !== e_a || bus.arid !== IDWID'(ar_cnt) || bus.arlen !== blen) begin
                     failures++;
                     $display("FAIL ar_beat: addr=%h id=%h len=%h, required %h %h %h",
                              bus.araddr, bus.arid, bus.arlen, e_a, IDWID'(ar_cnt), blen);
                  end
               end
               rq_addr.push_back(bus.araddr); rq_len.push_back(bus.arlen); rq_id.push_back(bus.arid);
               ar_cnt++;
            end
            hold_ar = bus.arvalid && !bus.arready;
            h_araddr = bus.araddr;
         end
      end
   end

   task automatic push_expect(input logic [31:0] base, input logic [7:0] nb, input logic [7:0] len);
      int nbi = (nb == 8'd0) ? 256 : int'(nb);
      int beats = int'(len) + 1;
      logic [31:0] a;
      for (int b = 0; b < nbi; b++) begin
         exp_aw.push_back(base + 32'(b * beats * 8));
         exp_ar.push_back(base + 32'(b * beats * 8));
      end
      for (int k = 0; k < nbi * beats; k++) begin
         a = base + 32'(k * 8);
         exp_w_addr.push_back(a);
         exp_w_data.push_back({~a, a});
      end
   endtask

   task automatic start_pulse(input logic [31:0] base, input logic [7:0] nb, input logic [7:0] len);
      @(negedge clk);
      base_addr = base; nbursts = nb; blen = len;
      aw_cnt = 0; ar_cnt = 0; w_seen = 0;
      start = 1;
      @(negedge clk);
      start = 0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         failures++;
         $display("FAIL busy_after_start: busy=%b done=%b, required 1 0", busy, done);
      end
   endtask

   task automatic run_bist(input logic [31:0] base, input logic [7:0] nb, input logic [7:0] len, input int budget);
      int cyc = 0;
      push_expect(base, nb, len);
      start_pulse(base, nb, len);
      while (!done && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL done_budget: done=%b after %0d cycles, required 1", done, cyc);
      end
      checks++;
      if (exp_w_addr.size() != 0 || exp_aw.size() != 0 || exp_ar.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: left w=%0d aw=%0d ar=%0d, required 0 0 0",
                  exp_w_addr.size(), exp_aw.size(), exp_ar.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, pass, timeout} !== 4'b0000 || err_cnt !== 16'h0) begin
         failures++;
         $display("FAIL reset_status: busy/done/pass/timeout=%b err=%h, required 0000 0", {busy, done, pass, timeout}, err_cnt);
      end
      checks++;
      if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 5'b0) begin
         failures++;
         $display("FAIL reset_valids: %b, required 00000", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready});
      end
      checks++;
      if (bus.awaddr !== 32'h0 || bus.araddr !== 32'h0 || bus.wdata !== 64'h0 || bus.awid !== '0) begin
         failures++;
         $display("FAIL reset_payload: awaddr=%h araddr=%h wdata=%h, required 0", bus.awaddr, bus.araddr, bus.wdata);
      end
      rst_n = 1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      run_bist(32'h100, 8'd2, 8'd3, 2000);
      checks++;
      if (w_seen != 8 || first_wdata !== 64'hFFFFFEFF_00000100) begin
         failures++;
         $display("FAIL basic_writes: beats=%0d first=%h, required 8 FFFFFEFF00000100", w_seen, first_wdata);
      end
      checks++;
      if ({done, pass, busy, timeout} !== 4'b1100 || err_cnt !== 16'h0) begin
         failures++;
         $display("FAIL basic_status: done/pass/busy/timeout=%b err=%0d, required 1100 0", {done, pass, busy, timeout}, err_cnt);
      end
   endtask

   task automatic test_corrupt();
      corrupt_en = 1;
      run_bist(32'h100, 8'd2, 8'd3, 2000);
      checks++;
      if (err_cnt !== 16'd1 || {done, pass} !== 2'b10) begin
         failures++;
         $display("FAIL corrupt_detect: err=%0d done/pass=%b, required 1 10", err_cnt, {done, pass});
      end
   endtask

   task automatic test_timeout();
      int cyc = 0;
      aw_stall = 1;
      start_pulse(32'h400, 8'd1, 8'd0);
      while (!timeout && cyc < 1200) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc < 1022 || cyc > 1026) begin
         failures++;
         $display("FAIL timeout_cycles: fired after %0d cycles, required about 1024", cyc);
      end
      checks++;
      if ({done, pass, timeout, busy} !== 4'b1010 || bus.awvalid !== 1'b0) begin
         failures++;
         $display("FAIL timeout_status: done/pass/timeout/busy=%b awvalid=%b, required 1010 0", {done, pass, timeout, busy}, bus.awvalid);
      end
      while (cyc < 1100) begin
         @(negedge clk);
         cyc++;
      end
      aw_stall = 0;
      repeat (5) @(negedge clk);
      checks++;
      if (bus.awvalid !== 1'b0 || done !== 1'b1) begin
         failures++;
         $display("FAIL timeout_hold: awvalid=%b done=%b, required 0 1", bus.awvalid, done);
      end
   endtask

   task automatic test_backpressure();
      bp = 1;
      run_bist(32'h2000, 8'd0, 8'd0, 40000);
      bp = 0;
      checks++;
      if (w_seen != 256 || ar_cnt != 256 || aw_cnt != 256) begin
         failures++;
         $display("FAIL bp_counts: w=%0d aw=%0d ar=%0d, required 256 256 256", w_seen, aw_cnt, ar_cnt);
      end
      checks++;
      if ({done, pass} !== 2'b11 || err_cnt !== 16'h0) begin
         failures++;
         $display("FAIL bp_status: done/pass=%b err=%0d, required 11 0", {done, pass}, err_cnt);
      end
   endtask

   task automatic test_reset_mid();
      int cyc = 0;
      push_expect(32'h100, 8'd2, 8'd3);
      start_pulse(32'h100, 8'd2, 8'd3);
      while (!(bus.wvalid && bus.awid == IDWID'(1)) && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (!(bus.wvalid && bus.awid == IDWID'(1))) begin
         failures++;
         $display("FAIL reset_mid_reach: wvalid=%b awid=%h, required W phase of burst 1", bus.wvalid, bus.awid);
      end
      #2 rst_n = 0;
      #1;
      checks++;
      if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, busy} !== 6'b0) begin
         failures++;
         $display("FAIL reset_mid_async: valids/readies/busy=%b, required 000000",
                  {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, busy});
      end
      repeat (2) @(negedge clk);
      exp_w_addr.delete(); exp_w_data.delete(); exp_aw.delete(); exp_ar.delete();
      rst_n = 1;
      @(negedge clk);
      run_bist(32'h100, 8'd2, 8'd3, 2000);
      checks++;
      if ({done, pass} !== 2'b11 || err_cnt !== 16'h0 || w_seen != 8) begin
         failures++;
         $display("FAIL reset_mid_rerun: done/pass=%b err=%0d beats=%0d, required 11 0 8", {done, pass}, err_cnt, w_seen);
      end
   endtask

   task automatic test_wrap();
      run_bist(32'hFFFF_FFF0, 8'd1, 8'd3, 2000);
      checks++;
      if ({done, pass} !== 2'b11 || w_seen != 4) begin
         failures++;
         $display("FAIL wrap_status: done/pass=%b beats=%0d, required 11 4", {done, pass}, w_seen);
      end
      checks++;
      if (!mem.exists(32'h0) || mem[32'h0] !== 64'hFFFFFFFF_00000000) begin
         failures++;
         $display("FAIL wrap_word0: exists=%0d, required word at 0 = FFFFFFFF00000000", mem.exists(32'h0));
      end
   endtask

   initial begin
      bp = 0; aw_stall = 0; corrupt_en = 0;
      aw_cnt = 0; ar_cnt = 0; w_seen = 0;
      test_reset();
      test_basic();
      test_corrupt();
      test_timeout();
      test_backpressure();
      test_reset_mid();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/axi_ram_bist_master.md
Name: axi_ram_bist_master

Overview:
- AXI4 master traffic generator/checker driving the slave port of axi2ram directly.
- On start: writes a deterministic address-derived pattern in INCR bursts, reads the same region back and compares every beat.
- Reports busy/done/pass, error count and timeout.
- Used as a self-checking stimulus source in RAM-path benches and as an on-chip memory BIST.

Parameters:
- IDWID, 4, AXI ID width.
- DWID, 64, data width; multiple of 64.
- WSTRB, DWID/8, strobe width (derived, not overridable).
- TIMEOUT, 1024, max cycles waiting on any single handshake.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; sampled only in IDLE/DONE.
- base_addr  in  32  start byte address; must be aligned to WSTRB.
- nbursts  in  8  burst count per phase; 0 means 256.
- blen  in  8  AXI len per burst (beats-1).
- busy  out  1  high from the cycle after start until DONE.
- done  out  1  sticky; cleared by the next start.
- pass  out  1  valid while done: err_cnt==0 and no timeout.
- timeout  out  1  sticky; cleared by start.
- err_cnt  out  16  saturating mismatch/response error counter.
- awaddr 32, awburst 2, awid IDWID, awlen 8, awsize 3, awvalid 1  out; awready  in  1.
- wdata DWID, wstrb WSTRB, wlast 1, wvalid 1  out; wready  in  1.
- bid IDWID, bresp 2, bvalid 1  in; bready  out  1.
- araddr 32, arburst 2, arid IDWID, arlen 8, arsize 3, arvalid 1  out; arready  in  1.
- rdata DWID, rid IDWID, rresp 2, rlast 1, rvalid 1  in; rready  out  1.

Behaviour:
- Reset: all valids/readies 0, addresses/data/ids 0, busy/done/pass/timeout 0, err_cnt 0, FSM IDLE. Reset mid-burst drops all valids immediately, no completion.
- Constants: awburst=arburst=2'b01 (INCR); awsize=arsize=log2(WSTRB); wstrb all ones; awid=arid=burst index[IDWID-1:0].
- Beat address A = base_addr + (b*(blen+1)+i)*WSTRB, 32-bit wrap-around, b=burst index, i=beat index.
- Pattern: wdata = DWID/64 copies of {~A, A}. Expected rdata uses the same function.
- FSM: IDLE -> AW -> W -> B -> (next burst ? AW : AR) -> R -> (next burst ? AR : DONE). DONE -> AW on start.
- start while busy is ignored.
- AW: awvalid held with stable payload until awready.
- W: wvalid held continuously; data advances only on wvalid&wready; wlast on beat blen.
- B: bready=1. Error (+1) if bresp!=0 or bid!=awid.
- AR: same rules as AW.
- R: rready=1 every cycle in R. Each accepted beat +1 error if rdata!=expected, rresp!=0, rid!=arid, or rlast!=(i==blen). Leave R on the beat with i==blen regardless of rlast.
- AXI rules: valid never deasserts before handshake; payload stable while valid&!ready.
- Watchdog: counter resets on every handshake and on state change. Reaching TIMEOUT in AW/W/B/AR/R sets timeout, drops valids and readies, goes to DONE.
- err_cnt saturates at 16'hFFFF.
- DONE: busy=0, done=1, pass=(err_cnt==0 && !timeout).
- Simultaneous events: start and an arriving handshake in the same cycle cannot occur (start sampled only in IDLE/DONE). Multiple errors on one beat count once.

Decomposition:
- Package axi_noc_pkg: burst encodings (INCR=2'b01), resp codes (OKAY=2'b00), FSM state enum, pattern function pat(A).
- One sub-module, axi_bist_addr_gen: burst/beat counters, beat address, last flags, next-burst decision. Shared by the write and read phases; the FSM stays in the top.

Test Plan:
- base=0x100, nbursts=2, blen=3, ideal axi2ram -> 8 W beats at 0x100..0x138 step 8; first wdata=64'hFFFFFEFF_00000100; done=1, pass=1, err_cnt=0.
- Corrupt RAM word at 0x110 (one bit) before read-back -> err_cnt=1, pass=0.
- Slave holds awready=0 for 1100 cycles, TIMEOUT=1024 -> timeout=1 after 1024 cycles, awvalid drops, done=1, pass=0.
- Random wready/rready backpressure, nbursts=0 (256), blen=0 -> 256 single-beat writes and reads, payload stable under stall, pass=1.
- rst_n low during the W phase of burst 1 -> all valids 0 asynchronously; new start re-runs cleanly with pass=1.
- base=0xFFFFFFF0, nbursts=1, blen=3 -> addresses 0xFFFFFFF0, 0xFFFFFFF8, 0x0, 0x8; pass=1.
